mole_game_ctrl: RTL and testbench

Parametrised game engine for the whack-a-mole HDMI demo: it replaces the fixed single-mole controller with a configurable hole count, several concurrent moles, per-mole lifetime, pause, miss counting and hit penalties. It sits between the UART command decoder and the display overlay. It consumes decoded key bytes and the video VSYNC, and drives game state, mole bitmap, score, miss count and remaining time to the renderer.

---
 rtl/mole_pkg.sv | 23 ++
 rtl/mole_game_ctrl_if.sv | 8 +
 rtl/mole_lfsr.sv | 16 +
 rtl/mole_game_ctrl.sv | 153 +++++++++++++++
 tb/tb_mole_game_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole game engine.
package mole_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    localparam logic [7:0]  KEY_START = 8'h53;
    localparam logic [7:0]  KEY_PAUSE = 8'h20;
    localparam logic [7:0]  KEY_HOLE0 = 8'h41;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/mole_game_ctrl_if.sv
// Decoded key stream from the UART command decoder into the game engine.
interface mole_game_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_data_en;

    modport master (output rx_data, output rx_data_en);
    modport slave  (input  rx_data, input  rx_data_en);
endinterface

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Galois LFSR; steps every clock so game start time varies the sequence.
module mole_lfsr
    import mole_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples its pre-edge inputs.
        if (rst) q <= LFSR_SEED;
        else     q <= lfsr_next(q);
    end

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game engine: turns key bytes and VSYNC frame ticks into game state,
// mole bitmap, score, misses and remaining time for the display overlay.
module mole_game_ctrl
    import mole_pkg::*;
#(
    parameter int HOLES        = 16,
    parameter int MAX_ACTIVE   = 2,
    parameter int FPS          = 60,
    parameter int GAME_SEC     = 60,
    parameter int SPAWN_FRAMES = 30,
    parameter int LIFE_FRAMES  = 90,
    parameter bit PENALTY      = 1'b1,
    parameter int SCORE_W      = 8,
    parameter int TIME_W       = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vs_in,
    mole_game_ctrl_if.slave    key,
    output logic [1:0]         state,
    output logic [HOLES-1:0]   mole_map,
    output logic [SCORE_W-1:0] mole_score,
    output logic [SCORE_W-1:0] miss_count,
    output logic [TIME_W-1:0]  left_time,
    output logic               hit_pulse
);

    localparam int         LIFE_W    = $clog2(LIFE_FRAMES + 1);
    localparam int         FRAME_W   = $clog2(FPS + 1);
    localparam int         SPAWN_W   = $clog2(SPAWN_FRAMES + 1);
    localparam int         SCORE_MAX = (1 << SCORE_W) - 1;
    localparam logic [7:0] HOLES_B   = 8'(HOLES);

    game_state_t        st;
    logic               vs_q, vs_d, tick;
    logic               key_v;
    logic [7:0]         key_b;
    logic [LIFE_W-1:0]  life [HOLES];
    logic [FRAME_W-1:0] frame_cnt;
    logic [SPAWN_W-1:0] spawn_cnt;
    logic [15:0]        lfsr_q;
    logic               lfsr_unused;

    mole_lfsr u_lfsr (.clk(clk), .rst(rst), .q(lfsr_q));

    // Only the low nibble picks a spawn hole.
    assign lfsr_unused = ^lfsr_q[15:4];
    assign state       = st;

    logic [7:0]       hole_off;
    logic             run_tick, hole_key, start_key, pause_key;
    logic             hit_ok, frame_wrap, spawn_slot, game_end, spawn_ok;
    logic [HOLES-1:0] hit_mask, cand_mask, expire_mask, map_next;
    int               active_cnt, expired_cnt, miss_total;

    always_comb begin
        // NOTE: every signal written here gets a value on every path, so no latch is inferred.
        hole_off    = key_b - KEY_HOLE0;
        run_tick    = tick && (st == RUN);
        start_key   = key_v && (key_b == KEY_START);
        pause_key   = key_v && (key_b == KEY_PAUSE);
        hole_key    = key_v && (st == RUN) && (key_b >= KEY_HOLE0) && (hole_off < HOLES_B);
        active_cnt  = 0;
        expired_cnt = 0;
        for (int i = 0; i < HOLES; i++) begin
            hit_mask[i]    = hole_key && (hole_off == 8'(i));
            cand_mask[i]   = (lfsr_q[3:0] == 4'(i));
            // A hit on the expiring hole wins over the miss.
            expire_mask[i] = run_tick && mole_map[i] && !hit_mask[i]
                          && (life[i] == LIFE_W'(LIFE_FRAMES - 1));
            if (mole_map[i])    active_cnt++;
            if (expire_mask[i]) expired_cnt++;
        end
        hit_ok     = |(hit_mask & mole_map);
        frame_wrap = run_tick && (frame_cnt == FRAME_W'(FPS - 1));
        spawn_slot = run_tick && (spawn_cnt == SPAWN_W'(SPAWN_FRAMES - 1));
        game_end   = frame_wrap && (left_time == TIME_W'(1));
        // Spawn judges the pre-cycle map and yields to any key aimed at the same hole.
        spawn_ok   = spawn_slot && !game_end && (|cand_mask) && (active_cnt < MAX_ACTIVE)
                  && !(|(cand_mask & (mole_map | hit_mask)));
        map_next   = game_end ? '0
                   : ((mole_map & ~hit_mask & ~expire_mask) | (spawn_ok ? cand_mask : '0));
        miss_total = int'(miss_count) + expired_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q       <= 1'b0;
            vs_d       <= 1'b0;
            tick       <= 1'b0;
            key_v      <= 1'b0;
            key_b      <= '0;
            st         <= IDLE;
            mole_map   <= '0;
            mole_score <= '0;
            miss_count <= '0;
            left_time  <= TIME_W'(GAME_SEC);
            hit_pulse  <= 1'b0;
            frame_cnt  <= '0;
            spawn_cnt  <= '0;
            // NOTE: the life counters live in flops, not RAM, so they are cleared on reset like any other state.
            for (int i = 0; i < HOLES; i++) life[i] <= '0;
        end else begin
            vs_q      <= vs_in;
            vs_d      <= vs_q;
            tick      <= vs_q && !vs_d;
            key_v     <= key.rx_data_en;
            key_b     <= key.rx_data;
            hit_pulse <= 1'b0;
            case (st)
                IDLE, OVER: begin
                    if (start_key) begin
                        st         <= RUN;
                        mole_map   <= '0;
                        mole_score <= '0;
                        miss_count <= '0;
                        left_time  <= TIME_W'(GAME_SEC);
                        frame_cnt  <= '0;
                        spawn_cnt  <= '0;
                        for (int i = 0; i < HOLES; i++) life[i] <= '0;
                    end
                end
                RUN: begin
                    mole_map  <= map_next;
                    hit_pulse <= hit_ok;
                    if (hit_ok) begin
                        if (mole_score != SCORE_W'(SCORE_MAX)) mole_score <= mole_score + 1'b1;
                    end else if (PENALTY && hole_key && (mole_score != '0)) begin
                        mole_score <= mole_score - 1'b1;
                    end
                    miss_count <= (miss_total > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE_W'(miss_total);
                    for (int i = 0; i < HOLES; i++) begin
                        if (spawn_ok && cand_mask[i])   life[i] <= '0;
                        else if (run_tick && mole_map[i]) life[i] <= life[i] + 1'b1;
                    end
                    if (run_tick) begin
                        frame_cnt <= frame_wrap ? '0 : frame_cnt + 1'b1;
                        spawn_cnt <= spawn_slot ? '0 : spawn_cnt + 1'b1;
                        if (frame_wrap) left_time <= left_time - 1'b1;
                    end
                    // A tick arriving with the pause key is still applied before freezing.
                    if (game_end)       st <= OVER;
                    else if (pause_key) st <= PAUSE;
                end
                PAUSE: begin
                    if (pause_key) st <= RUN;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Randomised bench for mole_game_ctrl: a tick-count based game model is compared with the
// DUT every cycle, plus literal expectations for reset, start, pause, game over and restart.
module tb_mole_game_ctrl;

    localparam int HOLES        = 6;
    localparam int MAX_ACTIVE   = 2;
    localparam int FPS          = 8;
    localparam int GAME_SEC     = 8;
    localparam int SPAWN_FRAMES = 3;
    localparam int LIFE_FRAMES  = 6;
    localparam bit PENALTY      = 1'b1;
    localparam int SCORE_W      = 3;
    localparam int TIME_W       = 4;
    localparam int SCORE_MAX    = (1 << SCORE_W) - 1;
    localparam int GAME_TICKS   = GAME_SEC * FPS;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               vs_in = 1'b0;
    logic [1:0]         state;
    logic [HOLES-1:0]   mole_map;
    logic [SCORE_W-1:0] mole_score;
    logic [SCORE_W-1:0] miss_count;
    logic [TIME_W-1:0]  left_time;
    logic               hit_pulse;

    mole_game_ctrl_if kif ();

    mole_game_ctrl #(
        .HOLES(HOLES), .MAX_ACTIVE(MAX_ACTIVE), .FPS(FPS), .GAME_SEC(GAME_SEC),
        .SPAWN_FRAMES(SPAWN_FRAMES), .LIFE_FRAMES(LIFE_FRAMES), .PENALTY(PENALTY),
        .SCORE_W(SCORE_W), .TIME_W(TIME_W)
    ) dut (
        .clk(clk), .rst(rst), .vs_in(vs_in), .key(kif),
        .state(state), .mole_map(mole_map), .mole_score(mole_score),
        .miss_count(miss_count), .left_time(left_time), .hit_pulse(hit_pulse)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: time is a count of RUN ticks since start; a mole expires LIFE_FRAMES ticks after birth.
    int          m_state, m_score, m_miss, m_ticks, m_hit;
    bit          m_up    [HOLES];
    int          m_birth [HOLES];
    logic [15:0] m_lfsr;
    bit          h1, h2, h3, kv;
    logic [7:0]  kb;

    task automatic model_reset();
        m_state = 0; m_score = 0; m_miss = 0; m_ticks = 0; m_hit = 0;
        for (int i = 0; i < HOLES; i++) begin
            m_up[i]    = 1'b0;
            m_birth[i] = 0;
        end
    endtask

    always @(posedge clk) begin
        bit tick_now, ended;
        bit was_up [HOLES];
        int hole, cand, n_up, k;
        if (rst) begin
            model_reset();
        end else begin
            tick_now = h2 && !h3;
            m_hit    = 0;
            ended    = 1'b0;
            hole     = -1;
            was_up   = m_up;
            k        = int'(kb);
            if (kv && k >= 'h41 && (k - 'h41) < HOLES) hole = k - 'h41;
            case (m_state)
                0, 3: begin
                    if (kv && kb == 8'h53) begin
                        m_state = 1; m_score = 0; m_miss = 0; m_ticks = 0;
                        for (int i = 0; i < HOLES; i++) m_up[i] = 1'b0;
                    end
                end
                1: begin
                    if (hole >= 0) begin
                        if (was_up[hole]) begin
                            m_up[hole] = 1'b0;
                            m_hit      = 1;
                            if (m_score < SCORE_MAX) m_score++;
                        end else if (PENALTY && m_score > 0) begin
                            m_score--;
                        end
                    end
                    if (tick_now) begin
                        m_ticks++;
                        for (int i = 0; i < HOLES; i++)
                            if (was_up[i] && i != hole && (m_ticks - m_birth[i]) == LIFE_FRAMES) begin
                                m_up[i] = 1'b0;
                                if (m_miss < SCORE_MAX) m_miss++;
                            end
                        if (m_ticks == GAME_TICKS) begin
                            ended   = 1'b1;
                            m_state = 3;
                            for (int i = 0; i < HOLES; i++) m_up[i] = 1'b0;
                        end else if (m_ticks % SPAWN_FRAMES == 0) begin
                            cand = int'(m_lfsr[3:0]);
                            n_up = 0;
                            for (int i = 0; i < HOLES; i++) if (was_up[i]) n_up++;
                            if (cand < HOLES && cand != hole && n_up < MAX_ACTIVE && !was_up[cand]) begin
                                m_up[cand]    = 1'b1;
                                m_birth[cand] = m_ticks;
                            end
                        end
                    end
                    if (!ended && kv && kb == 8'h20) m_state = 2;
                end
                default: begin
                    if (kv && kb == 8'h20) m_state = 1;
                end
            endcase
        end
        m_lfsr = rst ? 16'hACE1 : ((m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000));
        h3 = rst ? 1'b0 : h2;
        h2 = rst ? 1'b0 : h1;
        h1 = rst ? 1'b0 : vs_in;
        kv = rst ? 1'b0 : kif.rx_data_en;
        kb = kif.rx_data;
    end

    always @(negedge clk) begin
        logic [HOLES-1:0] exp_map;
        if (cmp_en) begin
            for (int i = 0; i < HOLES; i++) exp_map[i] = m_up[i];
            check("state", int'(state), m_state);
            check("mole_map", int'(mole_map), int'(exp_map));
            check("score", int'(mole_score), m_score);
            check("miss", int'(miss_count), m_miss);
            check("left_time", int'(left_time), GAME_SEC - m_ticks / FPS);
            check("hit_pulse", int'(hit_pulse), m_hit);
            check("max_active", int'($countones(mole_map) <= MAX_ACTIVE), 1);
        end
    end

    task automatic frame(input int len, input int slot, input logic [7:0] b);
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            vs_in          = (c < 2);
            kif.rx_data_en = (c == slot);
            kif.rx_data    = b;
        end
    endtask

    task automatic send_key(input logic [7:0] b);
        @(negedge clk);
        kif.rx_data_en = 1'b1;
        kif.rx_data    = b;
        @(negedge clk);
        kif.rx_data_en = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [7:0] pick_key();
        int r, best;
        r    = $urandom_range(0, 99);
        best = -1;
        if ((m_state == 0 || m_state == 3) && r < 50) return 8'h53;
        if (m_state == 2 && r < 30) return 8'h20;
        for (int i = 0; i < HOLES; i++)
            if (m_up[i] && (best < 0 || m_birth[i] < m_birth[best])) best = i;
        if (r < 50 && best >= 0) return 8'(8'h41 + best);
        if (r < 70) return 8'(8'h41 + $urandom_range(0, 7));
        if (r < 75) return 8'h20;
        if (r < 79) return 8'h53;
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic random_frames(input int n);
        int len, slot;
        logic [7:0] b;
        for (int f = 0; f < n; f++) begin
            len  = $urandom_range(4, 8);
            slot = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, len - 1);
            b    = pick_key();
            // Slot 1 lands the hit on the same edge as this frame's tick: aim it at an expiring mole.
            for (int i = 0; i < HOLES; i++)
                if (m_state == 1 && m_up[i] && (m_ticks - m_birth[i]) == LIFE_FRAMES - 1
                    && $urandom_range(0, 1) == 1) begin
                    slot = 1;
                    b    = 8'(8'h41 + i);
                end
            frame(len, slot, b);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_map"}, int'(mole_map), 0);
        check({tag, "_score"}, int'(mole_score), 0);
        check({tag, "_miss"}, int'(miss_count), 0);
        check({tag, "_time"}, int'(left_time), 8);
        check({tag, "_hit"}, int'(hit_pulse), 0);
    endtask

    initial begin
        kif.rx_data    = 8'h00;
        kif.rx_data_en = 1'b0;
        rst            = 1'b1;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check_reset_values("rst");
        rst = 1'b0;

        send_key(8'h53);
        check("start_state", int'(state), 1);
        check("start_time", int'(left_time), 8);

        send_key(8'h41);
        check("penalty_floor_score", int'(mole_score), 0);
        check("penalty_state", int'(state), 1);

        send_key(8'h20);
        check("pause_state", int'(state), 2);
        repeat (10) frame(5, 1, 8'h42);
        repeat (3) @(negedge clk);
        check("pause_time", int'(left_time), 8);
        check("pause_map", int'(mole_map), 0);
        send_key(8'h20);
        check("resume_state", int'(state), 1);

        repeat (GAME_TICKS) frame(4, -1, 8'h00);
        repeat (3) @(negedge clk);
        check("over_state", int'(state), 3);
        check("over_map", int'(mole_map), 0);
        check("over_time", int'(left_time), 0);

        send_key(8'h53);
        check("restart_state", int'(state), 1);
        check("restart_time", int'(left_time), 8);
        check("restart_score", int'(mole_score), 0);
        check("restart_miss", int'(miss_count), 0);

        random_frames(250);

        if (m_state != 1) send_key(m_state == 2 ? 8'h20 : 8'h53);
        frame(6, -1, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("midrst");

        random_frames(250);
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
